// File: rtl/vcss_err_pkg.sv
// ---------------------------------------------------------------------------
// vcss_err_pkg
//   Shared definitions for the vcss AXI4 error responder:
//     RESP_DECERR / RESP_SLVERR  AXI response codes
//     r_state_e                  read-channel FSM states
//     ERR_CNT_W                  width of the error transaction counter
//     sat_add()                  saturating add of 0..2 completions to the counter
// ---------------------------------------------------------------------------
package vcss_err_pkg;

  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned ERR_CNT_W = 16;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

  // Adds 0, 1 or 2 completions and clamps at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_add(
    input logic [ERR_CNT_W-1:0] cnt,
    input logic [1:0]           inc
  );
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_CNT_W-1){1'b0}}, inc};
    if (sum[ERR_CNT_W]) begin
      sat_add = {ERR_CNT_W{1'b1}};
    end else begin
      sat_add = sum[ERR_CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/vcss_err_id_fifo.sv
// ---------------------------------------------------------------------------
// vcss_err_id_fifo
//   Small FIFO holding AW IDs that are waiting for their W burst to finish.
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   without a separate occupancy counter.
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset (FIFO empties)
//   push_i          write push_id_i (ignored while full)
//   push_id_i       ID to store
//   pop_i           drop head entry (ignored while empty)
//   pop_id_o        ID at the head of the FIFO
//   full_o, empty_o occupancy flags
// ---------------------------------------------------------------------------
module vcss_err_id_fifo #(
  parameter int unsigned ID_W  = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  logic            pop_i,
  output logic [ID_W-1:0] pop_id_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [ID_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Same index with opposite wrap bit means the writer lapped the reader.
  assign full_s    = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                     (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign push_ok_s = push_i && !full_s;
  assign pop_ok_s  = pop_i && !empty_s;

  assign full_o   = full_s;
  assign empty_o  = empty_s;
  assign pop_id_o = mem_r[rd_ptr_r[IDX_W-1:0]];

  // Pointer update; push and pop in one cycle leave occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // ID storage, cleared on reset so the head never shows stale data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {ID_W{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r[IDX_W-1:0]] <= push_id_i;
    end
  end

endmodule

// File: rtl/vcss_axi_err_slv.sv
// ---------------------------------------------------------------------------
// vcss_axi_err_slv
//   AXI4 slave that answers every transaction with an error response. It sits
//   behind an unpopulated vcss slave port so masters never hang: write bursts
//   are drained and answered on B, read bursts return the full number of beats
//   with a fixed data pattern and correct RLAST.
//
// Optional feature (macro VCSS_ERR_SLV_CNT_EN):
//   defined   -> err_cnt_o counts completed B and R bursts, saturating at FFFF
//   undefined -> err_cnt_o is tied to zero and no counter is built
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   aw_* / aw_ready_o                  write address (ID kept, addr/len ignored)
//   w_* / w_ready_o                    write data (discarded, WLAST ends burst)
//   b_id_o, b_resp_o, b_valid_o, b_ready_i   write response
//   ar_* / ar_ready_o                  read address (ID and len used)
//   r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o, r_ready_i  read data
//   err_cnt_o                          error transaction counter
// ---------------------------------------------------------------------------
module vcss_axi_err_slv
  import vcss_err_pkg::*;
#(
  parameter int unsigned ID_W      = 9,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned AW_DEPTH  = 4,
  parameter logic [1:0]  RESP      = RESP_DECERR,
  parameter logic [63:0] RDATA_PAT = 64'hBADC_AB1E_BADC_AB1E
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // write address
  input  logic [ID_W-1:0]       aw_id_i,
  input  logic [ADDR_W-1:0]     aw_addr_i,
  input  logic [7:0]            aw_len_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  // write data
  input  logic [DATA_W-1:0]     w_data_i,
  input  logic [DATA_W/8-1:0]   w_strb_i,
  input  logic                  w_last_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  // write response
  output logic [ID_W-1:0]       b_id_o,
  output logic [1:0]            b_resp_o,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  // read address
  input  logic [ID_W-1:0]       ar_id_i,
  input  logic [ADDR_W-1:0]     ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  // read data
  output logic [ID_W-1:0]       r_id_o,
  output logic [DATA_W-1:0]     r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  // status
  output logic [ERR_CNT_W-1:0]  err_cnt_o
);

  // Repeat the 64-bit pattern across the data bus (truncates when narrower).
  function automatic logic [DATA_W-1:0] rep_pat(input logic [63:0] pat);
    for (int i = 0; i < int'(DATA_W); i++) begin
      rep_pat[i] = pat[i % 64];
    end
  endfunction

  localparam logic [DATA_W-1:0] RDATA_FULL = rep_pat(RDATA_PAT);

  // -------------------------------------------------------------------------
  // Common
  // -------------------------------------------------------------------------
  // Keeps every ready low while reset is asserted and for the first cycle after.
  logic rdy_en_r;

  // Address, data and strobes are accepted but never looked at.
  logic unused_in_s;
  assign unused_in_s = ^{aw_addr_i, aw_len_i, w_data_i, w_strb_i, ar_addr_i};

  // Ready enable comes up one cycle after reset is released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [ID_W-1:0] fifo_head_s;
  logic            aw_ready_s;
  logic            w_ready_s;
  logic            aw_hs_s;
  logic            w_last_hs_s;
  logic            b_hs_s;
  logic            b_valid_r;
  logic [ID_W-1:0] b_id_r;

  // No pop bypass: a full FIFO refuses AW even if WLAST pops this cycle.
  assign aw_ready_s  = rdy_en_r && !fifo_full_s;
  // W waits for a buffered AW and for the previous B to leave, keeping B in AW order.
  assign w_ready_s   = !fifo_empty_s && !b_valid_r;
  assign aw_hs_s     = aw_valid_i && aw_ready_s;
  assign w_last_hs_s = w_valid_i && w_ready_s && w_last_i;
  assign b_hs_s      = b_valid_r && b_ready_i;

  vcss_err_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (AW_DEPTH)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (aw_hs_s),
    .push_id_i (aw_id_i),
    .pop_i     (w_last_hs_s),
    .pop_id_o  (fifo_head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

  // B response register: loaded by WLAST, held until the master takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_valid_r <= 1'b0;
      b_id_r    <= {ID_W{1'b0}};
    end else if (w_last_hs_s) begin
      b_valid_r <= 1'b1;
      b_id_r    <= fifo_head_s;
    end else if (b_hs_s) begin
      b_valid_r <= 1'b0;
    end
  end

  assign aw_ready_o = aw_ready_s;
  assign w_ready_o  = w_ready_s;
  assign b_valid_o  = b_valid_r;
  assign b_id_o     = b_id_r;
  assign b_resp_o   = RESP;

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  r_state_e        r_state_r;
  r_state_e        r_state_s;
  logic [ID_W-1:0] r_id_r;
  logic [ID_W-1:0] r_id_s;
  logic [7:0]      r_len_r;
  logic [7:0]      r_len_s;
  logic [7:0]      r_cnt_r;
  logic [7:0]      r_cnt_s;
  logic            ar_ready_s;
  logic            r_valid_s;
  logic            r_last_s;

  // Read FSM registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_r <= R_IDLE;
      r_id_r    <= {ID_W{1'b0}};
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
    end else begin
      r_state_r <= r_state_s;
      r_id_r    <= r_id_s;
      r_len_r   <= r_len_s;
      r_cnt_r   <= r_cnt_s;
    end
  end

  // Read FSM next state and channel outputs.
  always_comb begin
    r_state_s  = r_state_r;
    r_id_s     = r_id_r;
    r_len_s    = r_len_r;
    r_cnt_s    = r_cnt_r;
    ar_ready_s = 1'b0;
    r_valid_s  = 1'b0;
    r_last_s   = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        ar_ready_s = rdy_en_r;
        if (ar_valid_i && rdy_en_r) begin
          r_state_s = R_BURST;
          r_id_s    = ar_id_i;
          r_len_s   = ar_len_i;
          r_cnt_s   = 8'd0;
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_BURST: begin
        r_valid_s = 1'b1;
        r_last_s  = (r_cnt_r == r_len_r);
        if (r_ready_i) begin
          if (r_last_s) begin
            r_state_s = R_IDLE;
          end else begin
            // Last beat leaves the counter alone, so len=255 never wraps it.
            r_cnt_s = r_cnt_r + 8'd1;
          end
        end else begin
          r_state_s = R_BURST;
        end
      end
      default: begin
        r_state_s = R_IDLE;
      end
    endcase
  end

  assign ar_ready_o = ar_ready_s;
  assign r_valid_o  = r_valid_s;
  assign r_last_o   = r_last_s;
  assign r_id_o     = r_id_r;
  assign r_data_o   = RDATA_FULL;
  assign r_resp_o   = RESP;

  // -------------------------------------------------------------------------
  // Error transaction counter
  // -------------------------------------------------------------------------
`ifdef VCSS_ERR_SLV_CNT_EN
  logic                 r_done_s;
  logic [1:0]           err_inc_s;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  assign r_done_s  = r_valid_s && r_ready_i && r_last_s;
  assign err_inc_s = {1'b0, b_hs_s} + {1'b0, r_done_s};

  // Counts finished B and R bursts; both in one cycle add two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else begin
      err_cnt_r <= sat_add(err_cnt_r, err_inc_s);
    end
  end

  assign err_cnt_o = err_cnt_r;
`else
  assign err_cnt_o = {ERR_CNT_W{1'b0}};
`endif

endmodule
